// File: rtl/platform_collider_pkg.sv
// Shared geometry constants, platform record type and level-1 reset layout
// for the platform collider and its table.
package platform_collider_pkg;

  localparam int COORD_W_DEF   = 16;
  localparam int MARIO_X_SIZE  = 16;
  localparam int MARIO_Y_SIZE  = 32;
  localparam int GND_HEIGHT    = 360;
  localparam int COLLIDER_TOL  = 4;
  localparam int NUM_INIT_PLAT = 5;

  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
  } plat_t;

  localparam plat_t PLATFORM1 = '{valid: 1'b1, x: 16'd200,  y: 16'd260, w: 16'd100, h: 16'd20};
  localparam plat_t PLATFORM2 = '{valid: 1'b1, x: 16'd400,  y: 16'd200, w: 16'd80,  h: 16'd16};
  localparam plat_t PLATFORM3 = '{valid: 1'b1, x: 16'd640,  y: 16'd280, w: 16'd120, h: 16'd20};
  localparam plat_t PLATFORM4 = '{valid: 1'b1, x: 16'd900,  y: 16'd220, w: 16'd100, h: 16'd16};
  localparam plat_t PLATFORM5 = '{valid: 1'b1, x: 16'd1200, y: 16'd180, w: 16'd80,  h: 16'd16};

  localparam plat_t PLAT_INIT [NUM_INIT_PLAT] = '{PLATFORM1, PLATFORM2, PLATFORM3, PLATFORM4, PLATFORM5};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reset content of table entry i; entries past the level layout start disabled.
  function automatic plat_t init_entry(input int i);
    logic [2:0] k;
    k = 3'(i);
    if (i < NUM_INIT_PLAT) begin
      init_entry = PLAT_INIT[k];
    end else begin
      init_entry = '0;
    end
  endfunction

endpackage

// File: rtl/platform_collider_table.sv
// Platform register file: level-1 layout on reset, one write port and one
// combinational read port driven by the scan counter.
module platform_collider_table
  import platform_collider_pkg::*;
#(
  parameter int NUM_PLAT = 8,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int IDX_W    = $clog2(NUM_PLAT)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic               wr_valid_i,
  input  logic [COORD_W-1:0] wr_x_i,
  input  logic [COORD_W-1:0] wr_y_i,
  input  logic [COORD_W-1:0] wr_w_i,
  input  logic [COORD_W-1:0] wr_h_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic [COORD_W-1:0] rd_x_o,
  output logic [COORD_W-1:0] rd_y_o,
  output logic [COORD_W-1:0] rd_w_o,
  output logic [COORD_W-1:0] rd_h_o
);

  logic               valid_a [NUM_PLAT];
  logic [COORD_W-1:0] x_a     [NUM_PLAT];
  logic [COORD_W-1:0] y_a     [NUM_PLAT];
  logic [COORD_W-1:0] w_a     [NUM_PLAT];
  logic [COORD_W-1:0] h_a     [NUM_PLAT];

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_ent
    localparam plat_t INIT_E = init_entry(g);
    logic               valid_q;
    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;

    // Entry storage: reload layout on reset, else take a matching write.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        valid_q <= INIT_E.valid;
        x_q     <= COORD_W'(INIT_E.x);
        y_q     <= COORD_W'(INIT_E.y);
        w_q     <= COORD_W'(INIT_E.w);
        h_q     <= COORD_W'(INIT_E.h);
      end else if (wr_en_i && (wr_idx_i == IDX_W'(g))) begin
        valid_q <= wr_valid_i;
        x_q     <= wr_x_i;
        y_q     <= wr_y_i;
        w_q     <= wr_w_i;
        h_q     <= wr_h_i;
      end
    end

    assign valid_a[g] = valid_q;
    assign x_a[g]     = x_q;
    assign y_a[g]     = y_q;
    assign w_a[g]     = w_q;
    assign h_a[g]     = h_q;
  end

  assign rd_valid_o = valid_a[rd_idx_i];
  assign rd_x_o     = x_a[rd_idx_i];
  assign rd_y_o     = y_a[rd_idx_i];
  assign rd_w_o     = w_a[rd_idx_i];
  assign rd_h_o     = h_a[rd_idx_i];

endmodule

// File: rtl/platform_collider.sv
// Per-frame scan of the platform table against Mario's world-space box,
// reporting floor height, ceiling hit and wall contacts.
module platform_collider
  import platform_collider_pkg::*;
#(
  parameter int NUM_PLAT = 8,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int TOL      = COLLIDER_TOL
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        frame_start_i,
  input  logic [COORD_W-1:0]          mario_x_i,
  input  logic [COORD_W-1:0]          mario_y_i,
  input  logic [COORD_W-1:0]          scroll_x_i,
  input  logic                        wr_en_i,
  input  logic [$clog2(NUM_PLAT)-1:0] wr_idx_i,
  input  logic                        wr_valid_i,
  input  logic [COORD_W-1:0]          wr_x_i,
  input  logic [COORD_W-1:0]          wr_y_i,
  input  logic [COORD_W-1:0]          wr_w_i,
  input  logic [COORD_W-1:0]          wr_h_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o,
  output logic                        floor_hit_o,
  output logic [COORD_W-1:0]          floor_y_o,
  output logic [$clog2(NUM_PLAT)-1:0] floor_idx_o,
  output logic                        ceil_hit_o,
  output logic                        wall_left_o,
  output logic                        wall_right_o
);

  localparam int IDX_W = $clog2(NUM_PLAT);
  localparam int SW    = COORD_W + 1;
  localparam logic [SW-1:0]    MW_C     = SW'(MARIO_X_SIZE);
  localparam logic [SW-1:0]    MH_C     = SW'(MARIO_Y_SIZE);
  localparam logic [SW-1:0]    TOL_C    = SW'(TOL);
  localparam logic [SW-1:0]    GND_C    = SW'(GND_HEIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);

  state_e state_q, state_d;
  logic load_s, scan_s, publish_s, busy_s;

  logic [IDX_W-1:0]   idx_q;
  logic [SW-1:0]      mx_q, my_q, best_q;
  logic [IDX_W-1:0]   fidx_acc_q;
  logic               fhit_acc_q, ceil_acc_q, wl_acc_q, wr_acc_q;
  logic               done_q, overrun_q, floor_hit_q, ceil_hit_q, wall_left_q, wall_right_q;
  logic [COORD_W-1:0] floor_y_q;
  logic [IDX_W-1:0]   floor_idx_q;

  logic               rd_valid_s;
  logic [COORD_W-1:0] rd_x_s, rd_y_s, rd_w_s, rd_h_s;
  logic [SW-1:0]      px_s, py_s, pw_s, ph_s;
  logic               hx_s, vy_s, floor_s, ceil_s, wl_s, wr_s;

  platform_collider_table #(.NUM_PLAT(NUM_PLAT), .COORD_W(COORD_W), .IDX_W(IDX_W)) u_table (
    .clk_i(clk_i), .reset_i(reset_i),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_valid_i(wr_valid_i),
    .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_w_i(wr_w_i), .wr_h_i(wr_h_i),
    .rd_idx_i(idx_q), .rd_valid_o(rd_valid_s),
    .rd_x_o(rd_x_s), .rd_y_o(rd_y_s), .rd_w_o(rd_w_s), .rd_h_o(rd_h_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start_i) state_d = ST_SCAN; else state_d = ST_IDLE;
      ST_SCAN: if (idx_q == LAST_IDX) state_d = ST_DONE; else state_d = ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    load_s    = 1'b0;
    scan_s    = 1'b0;
    publish_s = 1'b0;
    busy_s    = 1'b0;
    case (state_q)
      ST_IDLE: load_s = frame_start_i;
      ST_SCAN: begin scan_s = 1'b1; busy_s = 1'b1; end
      ST_DONE: begin publish_s = 1'b1; busy_s = 1'b1; end
      default: busy_s = 1'b0;
    endcase
  end

  assign px_s = {1'b0, rd_x_s};
  assign py_s = {1'b0, rd_y_s};
  assign pw_s = {1'b0, rd_w_s};
  assign ph_s = {1'b0, rd_h_s};

  // Contact tests for the entry under the scan pointer.
  always_comb begin
    hx_s    = rd_valid_s && (mx_q < px_s + pw_s) && (mx_q + MW_C > px_s);
    vy_s    = rd_valid_s && (my_q < py_s + ph_s) && (my_q + MH_C > py_s);
    floor_s = hx_s && (py_s + TOL_C >= my_q + MH_C) && (py_s < best_q);
    ceil_s  = hx_s && (py_s + ph_s <= my_q) && (py_s + ph_s + TOL_C >= my_q);
    wr_s    = vy_s && (mx_q + MW_C >= px_s) && (mx_q + MW_C < px_s + TOL_C);
    wl_s    = vy_s && (mx_q <= px_s + pw_s) && (mx_q + TOL_C > px_s + pw_s);
  end

  // Scan datapath: latch Mario, accumulate contacts, publish on DONE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q        <= '0;
      mx_q         <= '0;
      my_q         <= '0;
      best_q       <= GND_C;
      fidx_acc_q   <= '0;
      fhit_acc_q   <= 1'b0;
      ceil_acc_q   <= 1'b0;
      wl_acc_q     <= 1'b0;
      wr_acc_q     <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      floor_hit_q  <= 1'b0;
      floor_y_q    <= COORD_W'(GND_HEIGHT);
      floor_idx_q  <= '0;
      ceil_hit_q   <= 1'b0;
      wall_left_q  <= 1'b0;
      wall_right_q <= 1'b0;
    end else begin
      done_q    <= publish_s;
      overrun_q <= frame_start_i && busy_s;
      if (load_s) begin
        idx_q      <= '0;
        mx_q       <= SW'(mario_x_i) + SW'(scroll_x_i);
        my_q       <= SW'(mario_y_i);
        best_q     <= GND_C;
        fidx_acc_q <= '0;
        fhit_acc_q <= 1'b0;
        ceil_acc_q <= 1'b0;
        wl_acc_q   <= 1'b0;
        wr_acc_q   <= 1'b0;
      end else if (scan_s) begin
        idx_q <= idx_q + IDX_W'(1);
        if (floor_s) begin
          best_q     <= py_s;
          fidx_acc_q <= idx_q;
          fhit_acc_q <= 1'b1;
        end
        ceil_acc_q <= ceil_acc_q | ceil_s;
        wl_acc_q   <= wl_acc_q | wl_s;
        wr_acc_q   <= wr_acc_q | wr_s;
      end else if (publish_s) begin
        floor_hit_q  <= fhit_acc_q;
        floor_y_q    <= best_q[COORD_W-1:0];
        floor_idx_q  <= fidx_acc_q;
        ceil_hit_q   <= ceil_acc_q;
        wall_left_q  <= wl_acc_q;
        wall_right_q <= wr_acc_q;
      end
    end
  end

  assign busy_o       = busy_s;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;
  assign floor_hit_o  = floor_hit_q;
  assign floor_y_o    = floor_y_q;
  assign floor_idx_o  = floor_idx_q;
  assign ceil_hit_o   = ceil_hit_q;
  assign wall_left_o  = wall_left_q;
  assign wall_right_o = wall_right_q;

endmodule

// File: tb/tb_platform_collider.sv
// Self-checking bench for platform_collider: directed layout vectors,
// overrun/reset corner sequences and randomized scans against a table model.
module tb_platform_collider;

  localparam int NP  = 8;
  localparam int CW  = 16;
  localparam int LAT = NP + 2;

  logic          clk = 1'b0;
  logic          reset, frame_start, wr_en, wr_valid;
  logic [CW-1:0] mario_x, mario_y, scroll_x, wr_x, wr_y, wr_w, wr_h;
  logic [2:0]    wr_idx;
  logic          busy, done, overrun, floor_hit, ceil_hit, wall_left, wall_right;
  logic [CW-1:0] floor_y;
  logic [2:0]    floor_idx;

  int checks = 0;
  int failures = 0;

  platform_collider #(.NUM_PLAT(NP), .COORD_W(CW), .TOL(4)) dut (
    .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start),
    .mario_x_i(mario_x), .mario_y_i(mario_y), .scroll_x_i(scroll_x),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_valid_i(wr_valid),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_w_i(wr_w), .wr_h_i(wr_h),
    .busy_o(busy), .done_o(done), .overrun_o(overrun),
    .floor_hit_o(floor_hit), .floor_y_o(floor_y), .floor_idx_o(floor_idx),
    .ceil_hit_o(ceil_hit), .wall_left_o(wall_left), .wall_right_o(wall_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mx, my, sx;
    int fh, fy, fi, ce, wl, wr;
  } vec_t;

  vec_t vecs[6];

  // Reference table contents, held as plain integers.
  int m_v[NP], m_x[NP], m_y[NP], m_w[NP], m_h[NP];

  task automatic model_reset();
    int lx[5] = '{200, 400, 640, 900, 1200};
    int ly[5] = '{260, 200, 280, 220, 180};
    int lw[5] = '{100, 80, 120, 100, 80};
    int lh[5] = '{20, 16, 20, 16, 16};
    for (int i = 0; i < NP; i++) begin
      if (i < 5) begin
        m_v[i] = 1; m_x[i] = lx[i]; m_y[i] = ly[i]; m_w[i] = lw[i]; m_h[i] = lh[i];
      end else begin
        m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
      end
    end
  endtask

  // Behavioural collision model: pick highest reachable top, OR the contact flags.
  task automatic model(input int mx, input int my, output int fh, output int fy,
                       output int fi, output int ce, output int wl, output int wr);
    bit hx, vy;
    fh = 0; fy = 360; fi = 0; ce = 0; wl = 0; wr = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_v[i] != 0) begin
        hx = (mx < m_x[i] + m_w[i]) && (mx + 16 > m_x[i]);
        vy = (my < m_y[i] + m_h[i]) && (my + 32 > m_y[i]);
        if (hx && m_y[i] + 4 >= my + 32 && m_y[i] < fy) begin
          fh = 1; fy = m_y[i]; fi = i;
        end
        if (hx && m_y[i] + m_h[i] <= my && m_y[i] + m_h[i] + 4 >= my) ce = 1;
        if (vy && mx + 16 >= m_x[i] && mx + 16 < m_x[i] + 4) wr = 1;
        if (vy && mx <= m_x[i] + m_w[i] && mx + 4 > m_x[i] + m_w[i]) wl = 1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " floor_hit"}, int'(floor_hit), v.fh);
    check({tag, " floor_y"}, int'(floor_y), v.fy);
    check({tag, " floor_idx"}, int'(floor_idx), v.fi);
    check({tag, " ceil_hit"}, int'(ceil_hit), v.ce);
    check({tag, " wall_left"}, int'(wall_left), v.wl);
    check({tag, " wall_right"}, int'(wall_right), v.wr);
  endtask

  task automatic write_entry(input int i, input int v, input int x, input int y,
                             input int w, input int h);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 3'(i); wr_valid = (v != 0);
    wr_x = CW'(x); wr_y = CW'(y); wr_w = CW'(w); wr_h = CW'(h);
    @(negedge clk);
    wr_en = 1'b0;
    m_v[i] = v; m_x[i] = x; m_y[i] = y; m_w[i] = w; m_h[i] = h;
  endtask

  // Start a scan and return the cycle count until done (-1 on timeout).
  task automatic run_scan(input int mx, input int my, input int sx, output int lat);
    @(negedge clk);
    mario_x = CW'(mx); mario_y = CW'(my); scroll_x = CW'(sx);
    frame_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, dcnt, ocnt;
    vec_t r;
    vecs[0] = '{mx: 240, my: 228, sx: 0,   fh: 1, fy: 260, fi: 0, ce: 0, wl: 0, wr: 0};
    vecs[1] = '{mx: 50,  my: 328, sx: 0,   fh: 0, fy: 360, fi: 0, ce: 0, wl: 0, wr: 0};
    vecs[2] = '{mx: 240, my: 280, sx: 0,   fh: 0, fy: 360, fi: 0, ce: 1, wl: 0, wr: 0};
    vecs[3] = '{mx: 624, my: 270, sx: 0,   fh: 0, fy: 360, fi: 0, ce: 0, wl: 0, wr: 1};
    vecs[4] = '{mx: 240, my: 248, sx: 400, fh: 1, fy: 280, fi: 2, ce: 0, wl: 0, wr: 0};
    vecs[5] = '{mx: 110, my: 268, sx: 0,   fh: 1, fy: 300, fi: 7, ce: 0, wl: 0, wr: 0};

    reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_valid = 1'b0; wr_idx = '0;
    mario_x = '0; mario_y = '0; scroll_x = '0;
    wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset overrun", int'(overrun), 0);
    check_outputs("reset", '{mx: 0, my: 0, sx: 0, fh: 0, fy: 360, fi: 0, ce: 0, wl: 0, wr: 0});

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].mx, vecs[i].my, vecs[i].sx, lat);
      check($sformatf("vec%0d latency", i), lat, LAT);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // New floor at idx 7 plus a second frame_start mid-scan.
    write_entry(7, 1, 100, 300, 40, 20);
    @(negedge clk);
    mario_x = CW'(vecs[5].mx); mario_y = CW'(vecs[5].my); scroll_x = CW'(vecs[5].sx);
    frame_start = 1'b1;
    dcnt = 0; ocnt = 0; lat = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      frame_start = (k == 4);
      if (k == 5) check("overrun pulse", int'(overrun), 1);
      if (done) begin dcnt++; if (lat < 0) lat = k; end
      if (overrun) ocnt++;
    end
    check("overrun latency", lat, LAT);
    check("overrun done count", dcnt, 1);
    check("overrun pulse count", ocnt, 1);
    check_outputs("vec5", vecs[5]);

    // Reset mid-scan: no done pulse, outputs and table back to reset state.
    run_scan(240, 228, 0, lat);
    @(negedge clk);
    frame_start = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      reset = (k == 3);
      if (done) dcnt++;
    end
    model_reset();
    check("midreset done count", dcnt, 0);
    check("midreset busy", int'(busy), 0);
    check("midreset floor_y", int'(floor_y), 360);
    check("midreset floor_hit", int'(floor_hit), 0);

    for (int it = 0; it < 60; it++) begin
      int mx, my, sx, p;
      if ($urandom_range(0, 2) == 0) begin
        write_entry($urandom_range(0, NP - 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                    $urandom_range(0, 900), $urandom_range(150, 380),
                    $urandom_range(8, 200), $urandom_range(4, 60));
      end
      p = $urandom_range(0, NP - 1);
      if (it % 2 == 0 && m_v[p] != 0) begin
        mx = m_x[p] + $urandom_range(0, m_w[p]) - 8;
        if (mx < 0) mx = 0;
        my = m_y[p] - 32 + $urandom_range(0, 6) - 2;
        if (it % 4 == 0) my = m_y[p] + m_h[p] + $urandom_range(0, 6) - 1;
        if (my < 0) my = 0;
        sx = $urandom_range(0, (mx < 600) ? mx : 600);
      end else begin
        sx = $urandom_range(0, 400);
        mx = sx + $urandom_range(0, 620);
        my = $urandom_range(100, 360);
      end
      model(mx, my, r.fh, r.fy, r.fi, r.ce, r.wl, r.wr);
      run_scan(mx - sx, my, sx, lat);
      check($sformatf("rand%0d latency", it), lat, LAT);
      check_outputs($sformatf("rand%0d", it), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
